// File: rtl/reservation_station.sv
// Age-ordered, compacting reservation station with tag-broadcast wakeup.
// Optional macro RS_EMPTY_BYPASS_EN: same-cycle issue of a ready dispatch into an empty station.
module reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flash,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [31:0] disp_op,
  input  logic [63:0] disp_dest,
  input  logic        disp_src1_valid,
  input  logic        disp_src2_valid,
  input  logic [63:0] disp_src1,
  input  logic [63:0] disp_src2,
  input  logic        wb_en,
  input  logic [63:0] wb_tag,
  input  logic [31:0] wb_data,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_op,
  output logic [63:0] issue_dest,
  output logic [31:0] issue_src1,
  output logic [31:0] issue_src2
);
  localparam int SW = $clog2(DEPTH);

  logic        busy_reg [DEPTH];
  logic [31:0] op_reg   [DEPTH];
  logic [63:0] dest_reg [DEPTH];
  logic        v1_reg   [DEPTH];
  logic        v2_reg   [DEPTH];
  logic [63:0] s1_reg   [DEPTH];
  logic [63:0] s2_reg   [DEPTH];
  logic [4:0]  count_reg;

  logic        busy_next [DEPTH];
  logic [31:0] op_next   [DEPTH];
  logic [63:0] dest_next [DEPTH];
  logic        v1_next   [DEPTH];
  logic        v2_next   [DEPTH];
  logic [63:0] s1_next   [DEPTH];
  logic [63:0] s2_next   [DEPTH];
  logic [4:0]  count_next;

  // Post-wakeup view of every entry; the extra slot is an empty entry shifted into the top.
  logic        vw_busy [DEPTH+1];
  logic [31:0] vw_op   [DEPTH+1];
  logic [63:0] vw_dest [DEPTH+1];
  logic        vw_v1   [DEPTH+1];
  logic        vw_v2   [DEPTH+1];
  logic [63:0] vw_s1   [DEPTH+1];
  logic [63:0] vw_s2   [DEPTH+1];

  logic [DEPTH-1:0] ready;
  logic [SW-1:0]    sel;
  logic             any_ready;
  logic             clr, wb_act, bypass;
  logic             disp_fire, disp_alloc, issue_fire;
  logic             dhit1, dhit2;
  logic [4:0]       wr_pos;

  assign clr    = reset | flash;
  assign wb_act = wb_en & ~clr;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_view
      logic hit1, hit2;
      assign hit1         = wb_act & busy_reg[gi] & ~v1_reg[gi] & (s1_reg[gi] == wb_tag);
      assign hit2         = wb_act & busy_reg[gi] & ~v2_reg[gi] & (s2_reg[gi] == wb_tag);
      assign vw_busy[gi]  = busy_reg[gi];
      assign vw_op[gi]    = op_reg[gi];
      assign vw_dest[gi]  = dest_reg[gi];
      assign vw_v1[gi]    = v1_reg[gi] | hit1;
      assign vw_v2[gi]    = v2_reg[gi] | hit2;
      assign vw_s1[gi]    = hit1 ? {32'b0, wb_data} : s1_reg[gi];
      assign vw_s2[gi]    = hit2 ? {32'b0, wb_data} : s2_reg[gi];
      assign ready[gi]    = busy_reg[gi] & v1_reg[gi] & v2_reg[gi];
    end
  endgenerate

  assign vw_busy[DEPTH] = 1'b0;
  assign vw_op[DEPTH]   = '0;
  assign vw_dest[DEPTH] = '0;
  assign vw_v1[DEPTH]   = 1'b0;
  assign vw_v2[DEPTH]   = 1'b0;
  assign vw_s1[DEPTH]   = '0;
  assign vw_s2[DEPTH]   = '0;

  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel       = SW'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign disp_ready = (count_reg != 5'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready & ~clr;
  assign issue_fire = any_ready & issue_ready & ~clr;

`ifdef RS_EMPTY_BYPASS_EN
  assign bypass = disp_fire & (count_reg == 5'd0) & disp_src1_valid & disp_src2_valid & issue_ready;
`else
  assign bypass = 1'b0;
`endif

  assign disp_alloc = disp_fire & ~bypass;
  assign wr_pos     = count_reg - {4'b0, issue_fire};
  assign count_next = count_reg + {4'b0, disp_alloc} - {4'b0, issue_fire};

  // A dispatching operand can be woken by the broadcast in its own dispatch cycle.
  assign dhit1 = wb_act & ~disp_src1_valid & (disp_src1 == wb_tag);
  assign dhit2 = wb_act & ~disp_src2_valid & (disp_src2 == wb_tag);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (SW'(i) >= sel)) begin
        busy_next[i] = vw_busy[i+1];
        op_next[i]   = vw_op[i+1];
        dest_next[i] = vw_dest[i+1];
        v1_next[i]   = vw_v1[i+1];
        v2_next[i]   = vw_v2[i+1];
        s1_next[i]   = vw_s1[i+1];
        s2_next[i]   = vw_s2[i+1];
      end else begin
        busy_next[i] = vw_busy[i];
        op_next[i]   = vw_op[i];
        dest_next[i] = vw_dest[i];
        v1_next[i]   = vw_v1[i];
        v2_next[i]   = vw_v2[i];
        s1_next[i]   = vw_s1[i];
        s2_next[i]   = vw_s2[i];
      end
      if (disp_alloc && (wr_pos == 5'(i))) begin
        busy_next[i] = 1'b1;
        op_next[i]   = disp_op;
        dest_next[i] = disp_dest;
        v1_next[i]   = disp_src1_valid | dhit1;
        v2_next[i]   = disp_src2_valid | dhit2;
        s1_next[i]   = dhit1 ? {32'b0, wb_data} : disp_src1;
        s2_next[i]   = dhit2 ? {32'b0, wb_data} : disp_src2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) busy_reg[i] <= 1'b0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        busy_reg[i] <= busy_next[i];
        op_reg[i]   <= op_next[i];
        dest_reg[i] <= dest_next[i];
        v1_reg[i]   <= v1_next[i];
        v2_reg[i]   <= v2_next[i];
        s1_reg[i]   <= s1_next[i];
        s2_reg[i]   <= s2_next[i];
      end
    end
  end

  assign issue_valid = any_ready | bypass;
  assign issue_op    = bypass ? disp_op         : op_reg[sel];
  assign issue_dest  = bypass ? disp_dest       : dest_reg[sel];
  assign issue_src1  = bypass ? disp_src1[31:0] : s1_reg[sel][31:0];
  assign issue_src2  = bypass ? disp_src2[31:0] : s2_reg[sel][31:0];

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues are queued, a negedge monitor checks them.
module tb_reservation_station;
  logic        clock = 1'b0;
  logic        reset, flash, disp_valid, disp_ready;
  logic [31:0] disp_op;
  logic [63:0] disp_dest, disp_src1, disp_src2;
  logic        disp_src1_valid, disp_src2_valid;
  logic        wb_en;
  logic [63:0] wb_tag;
  logic [31:0] wb_data;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_op, issue_src1, issue_src2;
  logic [63:0] issue_dest;

  typedef struct packed {
    logic [31:0] op;
    logic [63:0] dest;
    logic [31:0] s1;
    logic [31:0] s2;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_rec, exp_rec;
  int   total = 0;
  int   bad   = 0;

  reservation_station #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .flash(flash),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_src1_valid(disp_src1_valid), .disp_src2_valid(disp_src2_valid),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_src1(issue_src1), .issue_src2(issue_src2)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && !flash && issue_valid && issue_ready) begin
      got_rec = '{issue_op, issue_dest, issue_src1, issue_src2};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected got op=%h dest=%h s1=%h s2=%h need none", issue_op, issue_dest, issue_src1, issue_src2);
      end else begin
        exp_rec = exp_q.pop_front();
        if (got_rec !== exp_rec) begin
          bad++;
          $display("FAIL issue_record got op=%h dest=%h s1=%h s2=%h need op=%h dest=%h s1=%h s2=%h",
                   got_rec.op, got_rec.dest, got_rec.s1, got_rec.s2, exp_rec.op, exp_rec.dest, exp_rec.s1, exp_rec.s2);
        end else begin
          $display("issue op=%h dest=%h s1=%h s2=%h ok", got_rec.op, got_rec.dest, got_rec.s1, got_rec.s2);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h need=%h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic disp(input logic [31:0] op, input logic [63:0] dest,
                      input logic v1, input logic [63:0] s1, input logic v2, input logic [63:0] s2);
    disp_valid      = 1'b1;
    disp_op         = op;
    disp_dest       = dest;
    disp_src1_valid = v1;
    disp_src1       = s1;
    disp_src2_valid = v2;
    disp_src2       = s2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flash = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_dest = '0;
    disp_src1 = '0; disp_src2 = '0; disp_src1_valid = 1'b0; disp_src2_valid = 1'b0;
    wb_en = 1'b0; wb_tag = '0; wb_data = '0; issue_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);

    // Simple ready dispatch: issues next cycle (same cycle with bypass).
    issue_ready = 1'b1;
    disp(32'h11, 64'h100, 1'b1, 64'd5, 1'b1, 64'd7);
    exp_q.push_back('{32'h11, 64'h100, 32'd5, 32'd7});
    #1;
`ifdef RS_EMPTY_BYPASS_EN
    chk("simple_same_cycle_iv", 64'(issue_valid), 64'd1);
    chk("simple_same_cycle_src1", 64'(issue_src1), 64'd5);
`else
    chk("simple_same_cycle_iv", 64'(issue_valid), 64'd0);
`endif
    cyc();
    disp_valid = 1'b0;
    #1;
`ifdef RS_EMPTY_BYPASS_EN
    chk("simple_next_iv", 64'(issue_valid), 64'd0);
`else
    chk("simple_next_iv", 64'(issue_valid), 64'd1);
    chk("simple_next_src1", 64'(issue_src1), 64'd5);
    chk("simple_next_src2", 64'(issue_src2), 64'd7);
`endif
    cyc();
    chk("simple_drained_iv", 64'(issue_valid), 64'd0);

    // Out-of-order: A waits on tag 3, younger B issues first.
    disp(32'h21, 64'h200, 1'b0, 64'h3, 1'b1, 64'd1);
    cyc();
    disp(32'h22, 64'h201, 1'b1, 64'd2, 1'b1, 64'd4);
    exp_q.push_back('{32'h22, 64'h201, 32'd2, 32'd4});
    exp_q.push_back('{32'h21, 64'h200, 32'h99, 32'd1});
    #1;
    chk("ooo_a_blocked_iv", 64'(issue_valid), 64'd0);
    cyc();
    disp_valid = 1'b0;
    #1;
    chk("ooo_b_first_op", 64'(issue_op), 64'h22);
    cyc();
    wb_en = 1'b1; wb_tag = 64'h3; wb_data = 32'h99;
    #1;
    chk("ooo_wb_cycle_iv", 64'(issue_valid), 64'd0);
    cyc();
    wb_en = 1'b0;
    #1;
    chk("ooo_a_woken_iv", 64'(issue_valid), 64'd1);
    chk("ooo_a_src1", 64'(issue_src1), 64'h99);
    cyc();
    chk("ooo_drained_iv", 64'(issue_valid), 64'd0);

    // Wakeup while the waiting entry shifts down past an issuing one.
    issue_ready = 1'b0;
    disp(32'h61, 64'h600, 1'b1, 64'd1, 1'b1, 64'd2);
    cyc();
    disp(32'h62, 64'h601, 1'b0, 64'h5, 1'b1, 64'd3);
    cyc();
    disp_valid = 1'b0;
    exp_q.push_back('{32'h61, 64'h600, 32'd1, 32'd2});
    exp_q.push_back('{32'h62, 64'h601, 32'h77, 32'd3});
    issue_ready = 1'b1; wb_en = 1'b1; wb_tag = 64'h5; wb_data = 32'h77;
    cyc();
    wb_en = 1'b0;
    #1;
    chk("shift_wake_op", 64'(issue_op), 64'h62);
    chk("shift_wake_src1", 64'(issue_src1), 64'h77);
    cyc();

    // Fill to full, hold a fifth dispatch, then drain.
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(32'h31 + 32'(i), 64'h300 + 64'(i), 1'b1, 64'(i), 1'b1, 64'(i + 10));
      exp_q.push_back('{32'h31 + 32'(i), 64'h300 + 64'(i), 32'(i), 32'(i + 10)});
      cyc();
    end
    disp(32'h35, 64'h304, 1'b1, 64'd4, 1'b1, 64'd14);
    exp_q.push_back('{32'h35, 64'h304, 32'd4, 32'd14});
    #1;
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    issue_ready = 1'b1;
    #1;
    chk("full_ready_indep", 64'(disp_ready), 64'd0);
    cyc();
    chk("after_issue_disp_ready", 64'(disp_ready), 64'd1);
    cyc();
    disp_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("full_drained_iv", 64'(issue_valid), 64'd0);

    // Dispatch-cycle wakeup of src2.
    disp(32'h41, 64'h400, 1'b1, 64'd9, 1'b0, 64'h8);
    wb_en = 1'b1; wb_tag = 64'h8; wb_data = 32'h42;
    exp_q.push_back('{32'h41, 64'h400, 32'd9, 32'h42});
    cyc();
    disp_valid = 1'b0; wb_en = 1'b0;
    #1;
    chk("disp_wake_iv", 64'(issue_valid), 64'd1);
    chk("disp_wake_src2", 64'(issue_src2), 64'h42);
    cyc();

    // Flash with three busy entries and a concurrent dispatch.
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(32'h51 + 32'(i), 64'h500, 1'b1, 64'd1, 1'b1, 64'd1);
      cyc();
    end
    flash = 1'b1;
    disp(32'h54, 64'h503, 1'b1, 64'd1, 1'b1, 64'd1);
    cyc();
    flash = 1'b0; disp_valid = 1'b0;
    #1;
    chk("flash_iv", 64'(issue_valid), 64'd0);
    chk("flash_disp_ready", 64'(disp_ready), 64'd1);
    issue_ready = 1'b1;
    cyc(); cyc();
    chk("flash_nothing_captured", 64'(issue_valid), 64'd0);

    // Reset mid-operation discards pending entries.
    issue_ready = 1'b0;
    disp(32'h71, 64'h700, 1'b1, 64'd1, 1'b1, 64'd1);
    cyc();
    disp(32'h72, 64'h701, 1'b1, 64'd1, 1'b1, 64'd1);
    cyc();
    disp_valid = 1'b0;
    reset = 1'b1; issue_ready = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_reset_iv", 64'(issue_valid), 64'd0);
    cyc();
    chk("mid_reset_still_empty", 64'(issue_valid), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
